edge_detector_array: RTL

Parametrised, multi-channel successor to the single-bit Mealy/Moore edge detectors. Each channel has an optional input synchroniser, a debounce filter, registered one-cycle rising/falling pulses and a saturating edge counter with synchronous clear. It sits between raw board inputs (buttons, switches, async strobes) and control FSMs that need clean, counted edge events.

---
 rtl/edge_pkg.sv | 33 +++
 rtl/edge_channel.sv | 153 +++++++++++++++
 rtl/edge_detector_array.sv | 54 +++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared types for the edge detector array: counter mode selection and the
// per-channel debounce state encoding.
package edge_pkg;

    // Which accepted edges advance a channel's edge counter.
    typedef enum logic [1:0] {
        EDGE_RISE,
        EDGE_FALL,
        EDGE_BOTH
    } count_mode_t;

    // Debounce FSM states; the filtered level is implied by the state.
    typedef enum logic [1:0] {
        IDLE_LOW,
        PEND_HIGH,
        IDLE_HIGH,
        PEND_LOW
    } debounce_state_t;

    // True when an accepted edge of the given direction should be counted.
    function automatic logic counts_edge(count_mode_t mode, logic rise, logic fall);
        logic hit;
        hit = 1'b0;
        unique case (mode)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One edge detector channel: optional synchroniser, debounce FSM, registered
// rise/fall pulses and a saturating edge counter with synchronous clear.
module edge_channel
    import edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COUNT_W         = 8,
    parameter count_mode_t COUNT_MODE      = EDGE_BOTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               clear,
    output logic               positive_edge,
    output logic               negative_edge,
    output logic [COUNT_W-1:0] edge_count
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [COUNT_W-1:0] CountMax = {COUNT_W{1'b1}};

    logic synced;

    if (SYNC_STAGES == 0) begin : gen_no_sync
        assign synced = in;
    end else begin : gen_sync
        logic [SYNC_STAGES-1:0] sync_q;

        // Shift the raw input through the synchroniser chain; oldest at the top.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= SYNC_STAGES'({sync_q, in});
            end
        end

        assign synced = sync_q[SYNC_STAGES-1];
    end

    debounce_state_t state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept_rise, accept_fall;

    // Debounce next-state: a new level must be seen DEBOUNCE_CYCLES times in a row.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        unique case (state_q)
            IDLE_LOW: begin
                if (synced) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d     = IDLE_HIGH;
                        accept_rise = 1'b1;
                    end else begin
                        state_d = PEND_HIGH;
                        cnt_d   = CntOne;
                    end
                end
            end
            PEND_HIGH: begin
                if (!synced) begin
                    // Glitch: drop back without a pulse.
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d     = IDLE_HIGH;
                    cnt_d       = '0;
                    accept_rise = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            IDLE_HIGH: begin
                if (!synced) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d     = IDLE_LOW;
                        accept_fall = 1'b1;
                    end else begin
                        state_d = PEND_LOW;
                        cnt_d   = CntOne;
                    end
                end
            end
            PEND_LOW: begin
                if (synced) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d     = IDLE_LOW;
                    cnt_d       = '0;
                    accept_fall = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Debounce state and counter registers; reset discards any pending edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic rise_q, fall_q;

    // Registered one-cycle pulses for accepted edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept_rise;
            fall_q <= accept_fall;
        end
    end

    logic               count_en;
    logic [COUNT_W-1:0] count_q;

    assign count_en = counts_edge(COUNT_MODE, accept_rise, accept_fall);

    // Saturating counter, updated on the same edge as the pulse; clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en && (count_q != CountMax)) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign positive_edge = rise_q;
    assign negative_edge = fall_q;
    assign edge_count    = count_q;

endmodule

// File: rtl/edge_detector_array.sv
// N independent debounced edge detector channels with a combined any-edge flag.
module edge_detector_array
    import edge_pkg::*;
#(
    parameter int unsigned N               = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COUNT_W         = 8,
    parameter count_mode_t COUNT_MODE      = EDGE_BOTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in,
    input  logic                 clear,
    output logic [N-1:0]         positive_edge,
    output logic [N-1:0]         negative_edge,
    output logic                 any_edge,
    output logic [N*COUNT_W-1:0] edge_count
);

    if (N < 1) begin : gen_bad_n
        $error("edge_detector_array: N must be at least 1");
    end
    if (SYNC_STAGES > 3) begin : gen_bad_sync
        $error("edge_detector_array: SYNC_STAGES must be 0..3");
    end
    if (DEBOUNCE_CYCLES < 1) begin : gen_bad_deb
        $error("edge_detector_array: DEBOUNCE_CYCLES must be at least 1");
    end
    if (COUNT_W < 1) begin : gen_bad_cw
        $error("edge_detector_array: COUNT_W must be at least 1");
    end

    for (genvar i = 0; i < N; i++) begin : gen_ch
        edge_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .COUNT_W        (COUNT_W),
            .COUNT_MODE     (COUNT_MODE)
        ) u_channel (
            .clk          (clk),
            .rst          (rst),
            .in           (in[i]),
            .clear        (clear),
            .positive_edge(positive_edge[i]),
            .negative_edge(negative_edge[i]),
            .edge_count   (edge_count[i*COUNT_W +: COUNT_W])
        );
    end

    // Pulses are already registered, so the OR is high in the pulse cycle itself.
    assign any_edge = |{positive_edge, negative_edge};

endmodule
